// File: rtl/edge_function_pkg.sv
// rtl/edge_function_pkg.sv - shared types and saturating shift helper for edge_function_tri
package edge_function_pkg;

  localparam int COORD_W = 16;
  localparam int WIDE_W  = 64;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef coord_t [1:0] vec2_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

  typedef struct packed {
    logic                     ovf;
    logic signed [WIDE_W-1:0] value;
  } sat_t;

  // Floor shift (arithmetic) followed by clipping to a signed out_w-bit range.
  function automatic sat_t sat_shift(input logic signed [WIDE_W-1:0] wide,
                                     input int frac_bits, input int out_w);
    logic signed [WIDE_W-1:0] sh;
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    sat_t r;
    sh = wide >>> frac_bits;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.ovf   = 1'b0;
    r.value = sh;
    if (sh > hi) begin
      r.ovf   = 1'b1;
      r.value = hi;
    end else if (sh < lo) begin
      r.ovf   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_function_tri_mac.sv
// rtl/edge_function_tri_mac.sv - exact edge-function multiply/subtract, MUL_STAGES deep, no stall
module edge_mac #(
  parameter int DATA_W     = 16,
  parameter int MUL_STAGES = 2,
  localparam int Z_W       = 2*DATA_W + 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0][DATA_W-1:0]       a,
  input  logic [1:0][DATA_W-1:0]       b,
  input  logic [1:0][DATA_W-1:0]       c,
  input  logic                         valid,
  input  logic [1:0]                   tag,
  output logic signed [Z_W-1:0]        z,
  output logic                         z_valid,
  output logic [1:0]                   z_tag
);

  localparam int D_W = DATA_W + 1;
  localparam int P_W = 2*DATA_W + 2;

  logic signed [D_W-1:0] dx_ca, dy_ba, dy_ca, dx_ba;
  logic signed [P_W-1:0] prod_a, prod_b;
  logic signed [Z_W-1:0] z_comb;

  // One guard bit on every difference keeps the full coordinate range exact.
  assign dx_ca = D_W'($signed(c[0])) - D_W'($signed(a[0]));
  assign dy_ba = D_W'($signed(b[1])) - D_W'($signed(a[1]));
  assign dy_ca = D_W'($signed(c[1])) - D_W'($signed(a[1]));
  assign dx_ba = D_W'($signed(b[0])) - D_W'($signed(a[0]));

  assign prod_a = P_W'(dx_ca) * P_W'(dy_ba);
  assign prod_b = P_W'(dy_ca) * P_W'(dx_ba);
  assign z_comb = Z_W'(prod_a) - Z_W'(prod_b);

  logic signed [Z_W-1:0] z_q [MUL_STAGES];
  logic [1:0]            t_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        z_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      v_q[0] <= valid;
      z_q[0] <= z_comb;
      t_q[0] <= tag;
      for (int i = 1; i < MUL_STAGES; i++) begin
        v_q[i] <= v_q[i-1];
        z_q[i] <= z_q[i-1];
        t_q[i] <= t_q[i-1];
      end
    end
  end

  assign z       = z_q[MUL_STAGES-1];
  assign z_valid = v_q[MUL_STAGES-1];
  assign z_tag   = t_q[MUL_STAGES-1];

endmodule

// File: rtl/edge_function_tri.sv
// rtl/edge_function_tri.sv - three edge functions per sample point; EDGE_FUNCTION_INSIDE_EN adds inside_o
module edge_function_tri
  import edge_function_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 0,
  parameter int OUT_W      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic [1:0][DATA_W-1:0] v0_i,
  input  logic [1:0][DATA_W-1:0] v1_i,
  input  logic [1:0][DATA_W-1:0] v2_i,
  input  logic [1:0][DATA_W-1:0] p_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [2:0][OUT_W-1:0]  w_o,
  output logic [2:0]             ovf_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
`ifdef EDGE_FUNCTION_INSIDE_EN
  ,
  output logic                   inside_o
`endif
);

  localparam int Z_W = 2*DATA_W + 3;

  state_e state_q, state_d;
  logic [1:0]              k_q;
  logic [1:0][DATA_W-1:0]  vert_q [3];
  logic [1:0][DATA_W-1:0]  pt_q;
  logic [1:0][DATA_W-1:0]  op_a, op_b;
  logic                    issue_valid;
  logic                    accept;
  logic                    done;

  logic signed [Z_W-1:0]   mac_z;
  logic                    mac_valid;
  logic [1:0]              mac_tag;
  sat_t                    mac_sat;
  logic [OUT_W-1:0]        cap_w;
  logic                    sat_unused;
  logic [2:0]              cap_bit;
  logic [2:0]              mask_q;

  logic [OUT_W-1:0]        slot_w [3];
  logic [2:0]              slot_ovf;
  logic [OUT_W-1:0]        merged_w [3];
  logic [2:0]              merged_ovf;

  assign accept = (state_q == IDLE) && in_valid_i;

  // Edge k pairs the two vertices that follow vertex k cyclically.
  always_comb begin
    op_a = vert_q[0];
    op_b = vert_q[1];
    case (k_q)
      2'd0: begin op_a = vert_q[1]; op_b = vert_q[2]; end
      2'd1: begin op_a = vert_q[2]; op_b = vert_q[0]; end
      default: begin op_a = vert_q[0]; op_b = vert_q[1]; end
    endcase
  end

  edge_mac #(
    .DATA_W     (DATA_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mac (
    .clk     (clk),
    .rst_n   (reset_i),
    .a       (op_a),
    .b       (op_b),
    .c       (pt_q),
    .valid   (issue_valid),
    .tag     (k_q),
    .z       (mac_z),
    .z_valid (mac_valid),
    .z_tag   (mac_tag)
  );

  assign mac_sat    = sat_shift(WIDE_W'(mac_z), FRAC_BITS, OUT_W);
  assign cap_w      = OUT_W'(mac_sat.value);
  assign sat_unused = ^mac_sat.value[WIDE_W-1:OUT_W];
  assign cap_bit    = mac_valid ? (3'b001 << mac_tag) : 3'b000;

  // Results arriving this cycle bypass their slot so the output loads on the final capture.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      merged_w[j]   = cap_bit[j] ? cap_w : slot_w[j];
      merged_ovf[j] = cap_bit[j] ? mac_sat.ovf : slot_ovf[j];
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_valid = 1'b0;
    done        = 1'b0;
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == OUT);
    case (state_q)
      IDLE:  if (in_valid_i) state_d = ISSUE;
      ISSUE: begin
        issue_valid = 1'b1;
        if (k_q == 2'd2) state_d = DRAIN;
      end
      DRAIN: if ((mask_q | cap_bit) == 3'b111) begin
        done    = 1'b1;
        state_d = OUT;
      end
      OUT:   if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      k_q      <= '0;
      mask_q   <= '0;
      pt_q     <= '0;
      slot_ovf <= '0;
      w_o      <= '0;
      ovf_o    <= '0;
      for (int j = 0; j < 3; j++) begin
        vert_q[j] <= '0;
        slot_w[j] <= '0;
      end
    end else begin
      if (accept) begin
        vert_q[0] <= v0_i;
        vert_q[1] <= v1_i;
        vert_q[2] <= v2_i;
        pt_q      <= p_i;
        k_q       <= 2'd0;
        mask_q    <= 3'b000;
      end else begin
        if (state_q == ISSUE) k_q <= k_q + 2'd1;
        mask_q <= mask_q | cap_bit;
      end
      for (int j = 0; j < 3; j++) begin
        if (cap_bit[j]) begin
          slot_w[j]   <= cap_w;
          slot_ovf[j] <= mac_sat.ovf;
        end
      end
      if (done) begin
        for (int j = 0; j < 3; j++) w_o[j] <= merged_w[j];
        ovf_o <= merged_ovf;
      end
    end
  end

`ifdef EDGE_FUNCTION_INSIDE_EN
  logic [2:0] w_neg, w_pos;

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      w_neg[j] = merged_w[j][OUT_W-1];
      w_pos[j] = !merged_w[j][OUT_W-1] && (|merged_w[j]);
    end
  end

  // Either winding counts as inside; zero lies on the edge and is inclusive.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i)  inside_o <= 1'b0;
    else if (done) inside_o <= !(|w_neg) || !(|w_pos);
  end
`endif

endmodule

// File: tb/tb_edge_function_tri.sv
// tb/tb_edge_function_tri.sv - randomized check of edge_function_tri against an arithmetic model
module tb_edge_function_tri;

  localparam int M   = 2;
  localparam int LAT = 3 + M;
  localparam int FR [3] = '{0, 0, 8};
  localparam int OW [3] = '{32, 16, 32};

  logic clk;
  logic reset_i;
  edge_function_pkg::vec2_t v0, v1, v2, p;
  logic in_valid, out_ready;
  logic [2:0] rdy, vld;
  logic [2:0][31:0] w_a, w_c;
  logic [2:0][15:0] w_b;
  logic [2:0] ovf_a, ovf_b, ovf_c;
  logic [2:0] ins;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  edge_function_tri #(.DATA_W(16), .FRAC_BITS(FR[0]), .OUT_W(OW[0]), .MUL_STAGES(M)) dut_a (
    .clk(clk), .reset_i(reset_i), .v0_i(v0), .v1_i(v1), .v2_i(v2), .p_i(p),
    .in_valid_i(in_valid), .in_ready_o(rdy[0]), .w_o(w_a), .ovf_o(ovf_a),
    .out_valid_o(vld[0]), .out_ready_i(out_ready)
`ifdef EDGE_FUNCTION_INSIDE_EN
    , .inside_o(ins[0])
`endif
  );

  edge_function_tri #(.DATA_W(16), .FRAC_BITS(FR[1]), .OUT_W(OW[1]), .MUL_STAGES(M)) dut_b (
    .clk(clk), .reset_i(reset_i), .v0_i(v0), .v1_i(v1), .v2_i(v2), .p_i(p),
    .in_valid_i(in_valid), .in_ready_o(rdy[1]), .w_o(w_b), .ovf_o(ovf_b),
    .out_valid_o(vld[1]), .out_ready_i(out_ready)
`ifdef EDGE_FUNCTION_INSIDE_EN
    , .inside_o(ins[1])
`endif
  );

  edge_function_tri #(.DATA_W(16), .FRAC_BITS(FR[2]), .OUT_W(OW[2]), .MUL_STAGES(M)) dut_c (
    .clk(clk), .reset_i(reset_i), .v0_i(v0), .v1_i(v1), .v2_i(v2), .p_i(p),
    .in_valid_i(in_valid), .in_ready_o(rdy[2]), .w_o(w_c), .ovf_o(ovf_c),
    .out_valid_o(vld[2]), .out_ready_i(out_ready)
`ifdef EDGE_FUNCTION_INSIDE_EN
    , .inside_o(ins[2])
`endif
  );

`ifndef EDGE_FUNCTION_INSIDE_EN
  assign ins = 3'b000;
`endif

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint edge_ref(input edge_function_pkg::vec2_t a,
                                      input edge_function_pkg::vec2_t b,
                                      input edge_function_pkg::vec2_t c);
    longint ax, ay, bx, by, cx, cy;
    ax = longint'($signed(a[0])); ay = longint'($signed(a[1]));
    bx = longint'($signed(b[0])); by = longint'($signed(b[1]));
    cx = longint'($signed(c[0])); cy = longint'($signed(c[1]));
    return (cx - ax) * (by - ay) - (cy - ay) * (bx - ax);
  endfunction

  // Floor division by 2^frac, then clip to the signed ow-bit range.
  task automatic sat_ref(input longint e, input int frac, input int ow,
                         output longint v, output bit o);
    longint d, s, hi, lo;
    d  = longint'(1) << frac;
    s  = (e >= 0) ? e / d : -((-e + d - 1) / d);
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -(longint'(1) << (ow - 1));
    o  = 1'b0;
    v  = s;
    if (s > hi) begin v = hi; o = 1'b1; end
    if (s < lo) begin v = lo; o = 1'b1; end
  endtask

  function automatic longint get_w(input int inst, input int j);
    case (inst)
      0:       return longint'($signed(w_a[j]));
      1:       return longint'($signed(w_b[j]));
      default: return longint'($signed(w_c[j]));
    endcase
  endfunction

  function automatic logic get_ovf(input int inst, input int j);
    case (inst)
      0:       return ovf_a[j];
      1:       return ovf_b[j];
      default: return ovf_c[j];
    endcase
  endfunction

  task automatic check_outputs(input edge_function_pkg::vec2_t a0, input edge_function_pkg::vec2_t a1,
                               input edge_function_pkg::vec2_t a2, input edge_function_pkg::vec2_t pp);
    longint e [3];
    longint sv;
    bit so, any_neg, any_pos;
    e[0] = edge_ref(a1, a2, pp);
    e[1] = edge_ref(a2, a0, pp);
    e[2] = edge_ref(a0, a1, pp);
    for (int inst = 0; inst < 3; inst++) begin
      any_neg = 1'b0;
      any_pos = 1'b0;
      for (int j = 0; j < 3; j++) begin
        sat_ref(e[j], FR[inst], OW[inst], sv, so);
        if (sv < 0) any_neg = 1'b1;
        if (sv > 0) any_pos = 1'b1;
        check($sformatf("w%0d_dut%0d", j, inst), get_w(inst, j), sv);
        check($sformatf("ovf%0d_dut%0d", j, inst), longint'(get_ovf(inst, j)), longint'(so));
      end
`ifdef EDGE_FUNCTION_INSIDE_EN
      check($sformatf("inside_dut%0d", inst), longint'(ins[inst]), longint'(!(any_neg && any_pos)));
`endif
    end
  endtask

  task automatic accept_set(input edge_function_pkg::vec2_t a0, input edge_function_pkg::vec2_t a1,
                            input edge_function_pkg::vec2_t a2, input edge_function_pkg::vec2_t pp);
    int cnt;
    cnt = 0;
    @(negedge clk);
    v0 = a0; v1 = a1; v2 = a2; p = pp;
    in_valid = 1'b1;
    while (!rdy[0] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_ready", longint'(rdy[0]), 1);
    if (rdy[0]) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_set(input edge_function_pkg::vec2_t a0, input edge_function_pkg::vec2_t a1,
                        input edge_function_pkg::vec2_t a2, input edge_function_pkg::vec2_t pp,
                        input int hold);
    out_ready = 1'b0;
    accept_set(a0, a1, a2, pp);
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_ready", longint'(rdy[0]), 0);
      if (i == LAT - 1) check("early_valid", longint'(vld), 0);
      out_ready = (i < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check("out_valid", longint'(vld), 7);
    check_outputs(a0, a1, a2, pp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", longint'(vld), 7);
      check("hold_ready", longint'(rdy), 0);
      check_outputs(a0, a1, a2, pp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_valid", longint'(vld), 0);
    check("post_ready", longint'(rdy), 7);
  endtask

  function automatic edge_function_pkg::vec2_t mk(input int x, input int y);
    edge_function_pkg::vec2_t r;
    r[0] = 16'(x);
    r[1] = 16'(y);
    return r;
  endfunction

  function automatic edge_function_pkg::vec2_t rnd_vec(input int mode);
    int x, y;
    case (mode)
      0: begin x = int'($urandom_range(0, 127)) - 64; y = int'($urandom_range(0, 127)) - 64; end
      1: begin x = int'($urandom_range(0, 65535)) - 32768; y = int'($urandom_range(0, 65535)) - 32768; end
      default: begin
        x = (int'($urandom_range(0, 127)) - 64) * 256;
        y = (int'($urandom_range(0, 127)) - 64) * 256;
      end
    endcase
    return mk(x, y);
  endfunction

  initial begin
    int mode;
    reset_i   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    v0 = '0; v1 = '0; v2 = '0; p = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", longint'(rdy), 7);
    check("rst_valid", longint'(vld), 0);
    check("rst_ovf", longint'({ovf_a, ovf_b, ovf_c}), 0);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_w%0d_a", j), get_w(0, j), 0);
      check($sformatf("rst_w%0d_b", j), get_w(1, j), 0);
      check($sformatf("rst_w%0d_c", j), get_w(2, j), 0);
    end
    @(negedge clk);
    reset_i = 1'b1;

    do_set(mk(0, 0), mk(4, 0), mk(0, 4), mk(1, 1), 0);
    do_set(mk(0, 0), mk(4, 0), mk(0, 4), mk(5, 5), 1);
    do_set(mk(-32768, -32768), mk(32767, -32768), mk(-32768, 32767), mk(32767, 32767), 10);
    do_set(mk(0, 0), mk(1024, 0), mk(0, 1024), mk(256, 256), 0);
    do_set(mk(3, 3), mk(3, 3), mk(3, 3), mk(3, 3), 0);

    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 2));
      do_set(rnd_vec(mode), rnd_vec(mode), rnd_vec(mode), rnd_vec(mode), int'($urandom_range(0, 3)));
    end

    // Reset while the third edge is still in the multiplier.
    accept_set(mk(0, 0), mk(4, 0), mk(0, 4), mk(1, 1));
    repeat (4) @(negedge clk);
    check("pre_rst_valid", longint'(vld), 0);
    reset_i = 1'b0;
    #1;
    check("midrst_valid", longint'(vld), 0);
    check("midrst_ready", longint'(rdy), 7);
    @(negedge clk);
    reset_i = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      check("no_stale_valid", longint'(vld), 0);
    end
    do_set(mk(0, 0), mk(4, 0), mk(0, 4), mk(5, 5), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
